// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t       : controller FSM encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH : default operand width in bits
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Lab single-bit full adder (combinational).
//   a, b, c_in : addend bits and carry-in
//   s          : sum bit
//   c_out      : carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per
// clock (LSB first) through a single full_adder, carry held in a flop.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin an addition (sampled only in IDLE)
//   a, b, c_in : operands and carry-in, captured on the accepted start
//   busy       : high while the addition is in progress
//   done       : one-cycle pulse when sum/c_out have been updated
//   sum, c_out : result of the last completed addition
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_sr_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c_out;
  logic             last_bit;

  full_adder u_full_adder (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c_out)
  );

  assign last_bit = (cnt == LAST_BIT);

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 of the
  // operands has landed in bit 0 of the result.  Written as a shift/or so
  // the same expression also covers WIDTH == 1.
  assign sum_sr_nxt = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= c_in;
            cnt    <= '0;
            sum_sr <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_c_out;
          sum_sr <= sum_sr_nxt;
          cnt    <= cnt + CNT_W'(1);
          // Outputs only move on the final bit, so partial sums never show.
          if (last_bit) begin
            sum   <= sum_sr_nxt;
            c_out <= fa_c_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences one `full_adder` instance to add two WIDTH-bit operands, one bit per clock, LSB first. It captures operands on a start handshake and shifts them through the adder while keeping the carry in a flip-flop. It presents the registered sum and carry-out with a one-cycle done pulse. It sits beside the existing `full_adder` as the lab's first sequential datapath, trading area for latency against a ripple-carry array.

## Interface

Parameters:
- WIDTH, default 8, operand and sum width in bits; legal range is WIDTH ≥ 1.

Ports:
- clk, input, 1, the single clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- start, input, 1, request to begin an addition; sampled only in IDLE.
- a, input, WIDTH, operand A; captured on the accepted start.
- b, input, WIDTH, operand B; captured on the accepted start.
- c_in, input, 1, carry-in; captured on the accepted start.
- busy, output, 1, high while the state is RUN.
- done, output, 1, one-cycle pulse while the state is DONE.
- sum, output, WIDTH, result of the last completed addition.
- c_out, output, 1, carry-out of the last completed addition.

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1. On that transition: load a_sr←a, b_sr←b, carry←c_in, cnt←0.
  - RUN: each cycle, feed a_sr[0], b_sr[0] and carry into `full_adder`.
    - Shift the s output into the sum shift register from the MSB side.
    - carry←c_out of the adder.
    - Shift a_sr and b_sr right by one.
    - cnt←cnt+1.
  - RUN → DONE on the edge that processes bit WIDTH-1 (cnt==WIDTH-1).
    - On that edge, sum←final shift-register contents and c_out←final carry.
  - DONE → IDLE unconditionally after one cycle.
- start is ignored in RUN and DONE; it is not queued.
- a, b and c_in may change freely after the accepted start.
- sum and c_out hold their value until the next completion. They never show partial results.
- Counter width is $clog2(WIDTH+1). It never wraps within an operation.
- The result is arithmetically exact: {c_out, sum} = a + b + c_in, modulo 2^(WIDTH+1).
- Reset (rst_n=0 at an edge), including mid-RUN: state←IDLE, busy=0, done=0, sum=0, c_out=0, and all internal registers cleared. The in-flight operation is discarded.

## Timing

- Reset values: busy=0, done=0, sum=0, c_out=0, state=IDLE.
- Start accepted at edge E0 (start=1 and state IDLE).
  - busy=1 from after E0 through edge E0+WIDTH.
  - Bit i is computed at edge E0+1+i.
  - sum and c_out are valid and done=1 after edge E0+WIDTH.
  - done falls after E0+WIDTH+1, and the block is back in IDLE.
- Latency is WIDTH+1 edges from accepted start to done.
- Throughput is one operation per WIDTH+2 cycles. A start held high continuously re-triggers in the first IDLE cycle.
- WIDTH=1: RUN lasts exactly one cycle, and done follows at E0+1.
- busy and done are never both high.

## Structure

- Shared package `serial_adder_pkg`:
  - state typedef state_t: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - a localparam for default WIDTH.
- Sub-module: exactly one existing `full_adder` instance, with ports (a, b, c_in, s, c_out). No new sub-module.
- Registers: a_sr, b_sr, sum_sr, carry, cnt, state, plus the output registers sum and c_out.

## Test plan

- Reset then idle, WIDTH=8, start=0 for 20 cycles → busy=0, done=0, sum=0x00, c_out=0 throughout.
- a=0x3C, b=0x42, c_in=0, start for 1 cycle → busy for 8 cycles, then done pulse 1 cycle with sum=0x7E, c_out=0.
- a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1.
  - Then a=0xA5, b=0x5A, c_in=1 → sum=0x00, c_out=1.
  - Prior sum holds until the second done.
- Start pulsed again 3 cycles into RUN with different operands → ignored; result matches the first operands; done fires exactly once.
- rst_n=0 for 1 cycle at RUN cycle 4 → next cycle busy=0, sum=0, c_out=0. A fresh start (0x01+0x01+0) gives sum=0x02, c_out=0.
- WIDTH=1 and WIDTH=4 builds, exhaustive over all a, b, c_in → {c_out,sum} equals a+b+c_in each time, and done occurs WIDTH+1 edges after start.
